fir_sample_source: RTL and testbench

Paced sample producer that drives the FIR filter's `signal_valid`/`signal` input stream. The HPS writes signed 16-bit samples into an internal FIFO. The block pops one sample per programmable rate tick and presents it to the filter as a single-cycle valid strobe. It sits between the CSR write path and the filter input, so software-generated test vectors advance the filter pipeline at a fixed sample rate.

---
 rtl/fir_sample_source.sv | 142 ++++++++++++++
 tb/tb_fir_sample_source.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_sample_source.sv
// fir_sample_source
// Paced sample producer for the FIR filter input stream. Software-written
// signed 16-bit samples are queued in a circular FIFO. One sample is popped
// per rate tick and presented as a single-cycle valid strobe.
//
// Ports:
//   clk, rst_n      system clock, synchronous active-low reset
//   enable          pacing counter runs only while high
//   rate_div        tick period is rate_div+1 cycles (applied at reload)
//   flush           single-cycle FIFO empty request
//   wr_valid/data   sample write from the CSR side; wr_ready = not full
//   signal_valid    one-cycle strobe to the filter
//   signal          sample to the filter; holds between strobes
//   fill_level      FIFO occupancy (registered count)
//   underflow       sticky: a tick found the FIFO empty
//   underflow_clr   single-cycle clear of underflow (a set wins)
module fir_sample_source #(
    parameter int DEPTH = 64,
    parameter int DIV_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [DIV_W-1:0]           rate_div,
    input  logic                       flush,
    input  logic                       wr_valid,
    input  logic [15:0]                wr_data,
    output logic                       wr_ready,
    output logic                       signal_valid,
    output logic [15:0]                signal,
    output logic [$clog2(DEPTH):0]     fill_level,
    output logic                       underflow,
    input  logic                       underflow_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [15:0]      mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic [DIV_W-1:0] cnt_q,    cnt_d;
    logic [15:0]      signal_q, signal_d;
    logic             signal_valid_q, signal_valid_d;
    logic             underflow_q, underflow_d;

    logic tick;
    logic fifo_empty;
    logic do_wr;
    logic do_pop;

    assign fifo_empty = (count_q == '0);
    assign wr_ready   = (count_q < CW'(DEPTH));
    assign tick       = enable && (cnt_q == '0);
    // A flush discards any write or pop issued in the same cycle.
    assign do_wr      = wr_valid && wr_ready && !flush;
    assign do_pop     = tick && !fifo_empty && !flush;

    always_comb begin
        cnt_d = cnt_q;
        if (!enable || cnt_q == '0) begin
            cnt_d = rate_div;
        end else begin
            cnt_d = cnt_q - DIV_W'(1);
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_wr) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({do_wr, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        signal_d       = signal_q;
        signal_valid_d = do_pop;
        if (do_pop) begin
            signal_d = mem_q[rd_ptr_q];
        end
    end

    // Set on an empty-FIFO tick takes priority over the clear.
    always_comb begin
        underflow_d = underflow_q;
        if (tick && fifo_empty) begin
            underflow_d = 1'b1;
        end else if (underflow_clr) begin
            underflow_d = 1'b0;
        end
    end

    // Sample storage needs no reset: occupancy is governed by the pointers.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            cnt_q          <= '0;
            signal_q       <= '0;
            signal_valid_q <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            cnt_q          <= cnt_d;
            signal_q       <= signal_d;
            signal_valid_q <= signal_valid_d;
            underflow_q    <= underflow_d;
        end
    end

    assign signal       = signal_q;
    assign signal_valid = signal_valid_q;
    assign fill_level   = count_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_fir_sample_source.sv
// Directed testbench for fir_sample_source (DEPTH overridden to 16).
module tb_fir_sample_source;

    localparam int DEPTH = 16;
    localparam int DIV_W = 16;
    localparam int FW    = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst_n;
    logic             enable;
    logic [DIV_W-1:0] rate_div;
    logic             flush;
    logic             wr_valid;
    logic [15:0]      wr_data;
    logic             wr_ready;
    logic             signal_valid;
    logic [15:0]      signal;
    logic [FW-1:0]    fill_level;
    logic             underflow;
    logic             underflow_clr;

    int unsigned n_cmp;
    int unsigned n_bad;

    fir_sample_source #(
        .DEPTH(DEPTH),
        .DIV_W(DIV_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .rate_div     (rate_div),
        .flush        (flush),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .signal_valid (signal_valid),
        .signal       (signal),
        .fill_level   (fill_level),
        .underflow    (underflow),
        .underflow_clr(underflow_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".signal_valid"}, 32'(signal_valid), 32'd0);
        check({tag, ".signal"},       32'(signal),       32'd0);
        check({tag, ".fill_level"},   32'(fill_level),   32'd0);
        check({tag, ".underflow"},    32'(underflow),    32'd0);
        check({tag, ".wr_ready"},     32'(wr_ready),     32'd1);
    endtask

    task automatic write_one(input logic [15:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        cyc();
        wr_valid = 1'b0;
    endtask

    logic [15:0] t1_vals [4];
    logic [15:0] exp_sig;
    int          exp_fill;
    logic        exp_sv;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        t1_vals[0] = 16'h0001;
        t1_vals[1] = 16'h7FFF;
        t1_vals[2] = 16'h8000;
        t1_vals[3] = 16'hFFFF;

        rst_n = 1'b0; enable = 1'b0; rate_div = 16'd3; flush = 1'b0;
        wr_valid = 1'b0; wr_data = '0; underflow_clr = 1'b0;
        cyc();
        cyc();
        check_reset_state("reset");
        rst_n = 1'b1;

        // ---- pacing at rate 3 ----
        for (int i = 0; i < 4; i++) write_one(t1_vals[i]);
        check("t1.fill_after_writes", 32'(fill_level), 32'd4);
        enable  = 1'b1;
        exp_sig = 16'h0000;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            exp_sv = (k % 4 == 0) && (k <= 16);
            if (exp_sv) exp_sig = t1_vals[k/4 - 1];
            exp_fill = (k >= 16) ? 0 : 4 - k / 4;
            check($sformatf("t1.sv[%0d]", k),   32'(signal_valid), 32'(exp_sv));
            check($sformatf("t1.sig[%0d]", k),  32'(signal),       32'(exp_sig));
            check($sformatf("t1.fill[%0d]", k), 32'(fill_level),   32'(exp_fill));
            check($sformatf("t1.uf[%0d]", k),   32'(underflow),    32'(k >= 20));
        end
        enable = 1'b0;
        underflow_clr = 1'b1;
        cyc();
        underflow_clr = 1'b0;
        check("t1.uf_cleared", 32'(underflow), 32'd0);

        // ---- fill to capacity ----
        rate_div = 16'd0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            wr_valid = 1'b1;
            wr_data  = 16'h1000 + 16'(i);
            check($sformatf("t2.wr_ready[%0d]", i), 32'(wr_ready), 32'(i < DEPTH));
            cyc();
        end
        wr_valid = 1'b0;
        check("t2.fill_full", 32'(fill_level), 32'(DEPTH));
        check("t2.wr_ready_full", 32'(wr_ready), 32'd0);
        enable = 1'b1;
        for (int k = 1; k <= DEPTH; k++) begin
            cyc();
            check($sformatf("t2.sv[%0d]", k),   32'(signal_valid), 32'd1);
            check($sformatf("t2.sig[%0d]", k),  32'(signal),       32'(16'h1000 + 16'(k - 1)));
            check($sformatf("t2.fill[%0d]", k), 32'(fill_level),   32'(DEPTH - k));
        end
        cyc();
        check("t2.sv_after_drain", 32'(signal_valid), 32'd0);
        check("t2.sig_hold",       32'(signal),       32'(16'h1000 + 16'(DEPTH - 1)));
        check("t2.uf_after_drain", 32'(underflow),    32'd1);
        enable = 1'b0;
        underflow_clr = 1'b1;
        cyc();
        underflow_clr = 1'b0;

        // ---- continuous rate with concurrent writes ----
        write_one(16'h2000);
        check("t3.fill_start", 32'(fill_level), 32'd1);
        enable = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            wr_valid = 1'b1;
            wr_data  = 16'h2000 + 16'(k);
            cyc();
            check($sformatf("t3.sv[%0d]", k),   32'(signal_valid), 32'd1);
            check($sformatf("t3.sig[%0d]", k),  32'(signal),       32'(16'h2000 + 16'(k - 1)));
            check($sformatf("t3.fill[%0d]", k), 32'(fill_level),   32'd1);
        end
        wr_valid = 1'b0;
        enable   = 1'b0;
        cyc();
        check("t3.fill_end", 32'(fill_level), 32'd1);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        check("t3.flush_fill", 32'(fill_level), 32'd0);
        check("t3.flush_sig",  32'(signal),     32'h2007);
        check("t3.flush_uf",   32'(underflow),  32'd0);

        // ---- flush mid-stream ----
        rate_div = 16'd2;
        for (int i = 0; i < 10; i++) write_one(16'h3000 + 16'(i));
        check("t4.fill10", 32'(fill_level), 32'd10);
        enable = 1'b1;
        cyc();
        cyc();
        check("t4.no_early_sv", 32'(signal_valid), 32'd0);
        cyc();
        check("t4.first_sv",  32'(signal_valid), 32'd1);
        check("t4.first_sig", 32'(signal),       32'h3000);
        check("t4.fill9",     32'(fill_level),   32'd9);
        cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        check("t4.flush_fill", 32'(fill_level), 32'd0);
        check("t4.flush_sv",   32'(signal_valid), 32'd0);
        cyc();
        check("t4.tick_empty_sv",  32'(signal_valid), 32'd0);
        check("t4.tick_empty_uf",  32'(underflow),    32'd1);
        check("t4.tick_empty_sig", 32'(signal),       32'h3000);
        underflow_clr = 1'b1;
        cyc();
        underflow_clr = 1'b0;
        check("t4.uf_clr", 32'(underflow), 32'd0);
        cyc();
        underflow_clr = 1'b1;
        cyc();
        underflow_clr = 1'b0;
        check("t4.uf_set_wins", 32'(underflow), 32'd1);
        enable = 1'b0;
        cyc();

        // ---- reset mid-operation ----
        for (int i = 0; i < 6; i++) write_one(16'h4000 + 16'(i));
        enable = 1'b1;
        cyc();
        cyc();
        cyc();
        check("t5.sv_pulse", 32'(signal_valid), 32'd1);
        check("t5.fill5",    32'(fill_level),   32'd5);
        check("t5.uf_before", 32'(underflow),   32'd1);
        rst_n  = 1'b0;
        enable = 1'b0;
        cyc();
        rst_n = 1'b1;
        check_reset_state("t5.after_rst");
        write_one(16'h5555);
        enable = 1'b1;
        cyc();
        check("t5.re_sv1", 32'(signal_valid), 32'd0);
        cyc();
        check("t5.re_sv2", 32'(signal_valid), 32'd0);
        cyc();
        check("t5.re_sv3",  32'(signal_valid), 32'd1);
        check("t5.re_sig",  32'(signal),       32'h5555);
        check("t5.re_fill", 32'(fill_level),   32'd0);
        enable = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
